// File: rtl/sys_cmd_decoder_pkg.sv
// sys_cmd_decoder_pkg
//   Shared definitions for the command-frame decoder: frame opcodes, the
//   decoder state encoding, the register addresses that hold the ALU
//   operands, and a helper that says which states refuse incoming bytes.
package sys_cmd_decoder_pkg;

  // Frame opcodes (first byte of every frame)
  localparam logic [7:0] CMD_WR      = 8'hAA;  // AA addr data
  localparam logic [7:0] CMD_RD      = 8'hBB;  // BB addr
  localparam logic [7:0] CMD_ALU     = 8'hCC;  // CC opA opB func
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // DD func (operands already loaded)

  // Register-file locations of the ALU operands
  localparam int unsigned ALU_A_ADDR = 0;
  localparam int unsigned ALU_B_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUNC,
    ST_ALU_WAIT,
    ST_TX_BYTE,
    ST_TX_HI
  } state_e;

  // States in which the decoder is waiting on the register file, the ALU or
  // the TX FIFO; a byte arriving here cannot be parsed and is discarded.
  function automatic logic rx_blocked(input state_e s);
    return (s == ST_RD_WAIT) || (s == ST_ALU_WAIT) ||
           (s == ST_TX_BYTE) || (s == ST_TX_HI);
  endfunction

endpackage

// File: rtl/sys_cmd_decoder.sv
// sys_cmd_decoder
//   Parses received command frames (write / read / ALU op / ALU op without
//   operands), drives the register file and the ALU with one-cycle strobes,
//   and returns read data or the 16-bit ALU result (low byte first) to the
//   TX FIFO, stalling while the FIFO reports full. Every output is a
//   register.
//
// Ports
//   CLK, RST        reference clock, asynchronous active-high reset
//   RX_P_DATA/VLD   received byte and its single-cycle valid strobe
//   WrEn/RdEn       register-file write/read strobes
//   Address/WrData  register-file address and write data (held between strobes)
//   RdData(_Valid)  register-file read response
//   ALU_FUN/ALU_EN  ALU function code and start strobe
//   CLKG_EN         ALU clock-gate enable, high while an ALU op is pending
//   ALU_OUT/OUT_Valid ALU result and its valid strobe
//   TX_P_DATA/TX_D_VLD byte and write strobe toward the TX FIFO
//   FIFO_FULL       TX FIFO full flag (backpressure)
//   DROP            pulse: a byte arrived while the decoder was busy
module sys_cmd_decoder
  import sys_cmd_decoder_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int ALU_OUT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic                 WrEn,
  output logic                 RdEn,
  output logic [ADDR_W-1:0]    Address,
  output logic [DATA_W-1:0]    WrData,
  input  logic [DATA_W-1:0]    RdData,
  input  logic                 RdData_Valid,
  output logic [3:0]           ALU_FUN,
  output logic                 ALU_EN,
  output logic                 CLKG_EN,
  input  logic [ALU_OUT_W-1:0] ALU_OUT,
  input  logic                 OUT_Valid,
  output logic [DATA_W-1:0]    TX_P_DATA,
  output logic                 TX_D_VLD,
  input  logic                 FIFO_FULL,
  output logic                 DROP
);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_addr_q;   // address byte of a write frame
  logic [DATA_W-1:0]   hi_q;        // ALU result high byte, sent second
  logic                resp_alu_q;  // pending response is a two-byte ALU result

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      hi_q       <= '0;
      resp_alu_q <= 1'b0;
      WrEn       <= 1'b0;
      RdEn       <= 1'b0;
      ALU_EN     <= 1'b0;
      TX_D_VLD   <= 1'b0;
      CLKG_EN    <= 1'b0;
      DROP       <= 1'b0;
      Address    <= '0;
      WrData     <= '0;
      TX_P_DATA  <= '0;
      ALU_FUN    <= '0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      ALU_EN   <= 1'b0;
      TX_D_VLD <= 1'b0;
      DROP     <= RX_D_VLD && rx_blocked(state_q);

      case (state_q)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            // Unknown opcodes are silently ignored, not reported as drops.
            case (RX_P_DATA)
              DATA_W'(CMD_WR):      state_q <= ST_WR_ADDR;
              DATA_W'(CMD_RD):      state_q <= ST_RD_ADDR;
              DATA_W'(CMD_ALU):     state_q <= ST_ALU_A;
              DATA_W'(CMD_ALU_NOP): begin
                state_q <= ST_ALU_FUNC;
                CLKG_EN <= 1'b1;
              end
              default:              state_q <= ST_IDLE;
            endcase
          end
        end

        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            wr_addr_q <= RX_P_DATA[ADDR_W-1:0];
            state_q   <= ST_WR_DATA;
          end
        end

        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            WrEn    <= 1'b1;
            Address <= wr_addr_q;
            WrData  <= RX_P_DATA;
            state_q <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            RdEn    <= 1'b1;
            Address <= RX_P_DATA[ADDR_W-1:0];
            state_q <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          // The byte goes straight onto the TX bus; if the FIFO is full it
          // is parked there (no strobe) until TX_BYTE sees room.
          if (RdData_Valid) begin
            resp_alu_q <= 1'b0;
            TX_P_DATA  <= RdData;
            TX_D_VLD   <= !FIFO_FULL;
            state_q    <= FIFO_FULL ? ST_TX_BYTE : ST_IDLE;
          end
        end

        ST_ALU_A: begin
          if (RX_D_VLD) begin
            WrEn    <= 1'b1;
            Address <= ADDR_W'(ALU_A_ADDR);
            WrData  <= RX_P_DATA;
            state_q <= ST_ALU_B;
          end
        end

        ST_ALU_B: begin
          if (RX_D_VLD) begin
            WrEn    <= 1'b1;
            Address <= ADDR_W'(ALU_B_ADDR);
            WrData  <= RX_P_DATA;
            CLKG_EN <= 1'b1;
            state_q <= ST_ALU_FUNC;
          end
        end

        ST_ALU_FUNC: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[3:0];
            ALU_EN  <= 1'b1;
            state_q <= ST_ALU_WAIT;
          end
        end

        ST_ALU_WAIT: begin
          if (OUT_Valid) begin
            resp_alu_q <= 1'b1;
            hi_q       <= ALU_OUT[2*DATA_W-1:DATA_W];
            TX_P_DATA  <= ALU_OUT[DATA_W-1:0];
            TX_D_VLD   <= !FIFO_FULL;
            CLKG_EN    <= 1'b0;
            state_q    <= FIFO_FULL ? ST_TX_BYTE : ST_TX_HI;
          end
        end

        ST_TX_BYTE: begin
          // TX_P_DATA already holds the pending byte.
          if (!FIFO_FULL) begin
            TX_D_VLD <= 1'b1;
            state_q  <= resp_alu_q ? ST_TX_HI : ST_IDLE;
          end
        end

        ST_TX_HI: begin
          // Loading the high byte here is harmless while stalled: no strobe
          // accompanies it until the FIFO has room.
          TX_P_DATA <= hi_q;
          if (!FIFO_FULL) begin
            TX_D_VLD <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sys_cmd_decoder.md
# sys_cmd_decoder

Command-frame decoder and response sequencer sitting directly downstream of the UART receiver (after the RX data synchroniser) in the reference-clock domain of SYS_TOP. It consumes received bytes, parses the 0xAA/0xBB/0xCC/0xDD command frames, drives the register file and ALU, and pushes response bytes into the TX FIFO with full-flag backpressure.

## Interface
- DATA_W, 8, byte width of RX/TX/register data
- ADDR_W, 4, register-file address width; the low ADDR_W bits of an address byte are used
- ALU_OUT_W, 16, ALU result width; two bytes are sent per result
- CLK  in  1  reference clock
- RST  in  1  asynchronous, active-high reset
- RX_P_DATA  in  DATA_W  synchronised received byte
- RX_D_VLD  in  1  single-cycle strobe, RX_P_DATA valid
- WrEn / RdEn  out  1  register-file write / read strobes, one cycle each
- Address  out  ADDR_W  register-file address
- WrData  out  DATA_W  register-file write data
- RdData  in  DATA_W  register-file read data
- RdData_Valid  in  1  read data valid, one cycle after RdEn
- ALU_FUN  out  4  ALU function code
- ALU_EN  out  1  ALU start strobe, one cycle
- CLKG_EN  out  1  ALU clock-gate enable
- ALU_OUT  in  ALU_OUT_W  ALU result
- OUT_Valid  in  1  ALU result valid, one cycle after ALU_EN
- TX_P_DATA  out  DATA_W  byte to TX FIFO
- TX_D_VLD  out  1  FIFO write strobe, one cycle per byte
- FIFO_FULL  in  1  TX FIFO full
- DROP  out  1  one-cycle pulse, byte received while decoder not accepting

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUNC, ALU_WAIT, TX_BYTE, TX_HI.
- IDLE: on RX_D_VLD, 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→ALU_A, 0xDD→ALU_FUNC; any other byte ignored (no DROP), stay IDLE.
- WR_ADDR: latch address → WR_DATA. WR_DATA: next byte → WrEn=1 with latched Address, WrData=byte; → IDLE. No response byte.
- RD_ADDR: byte → RdEn=1, Address=byte[ADDR_W-1:0]; → RD_WAIT. RD_WAIT: on RdData_Valid latch RdData → TX_BYTE.
- ALU_A: byte → WrEn, Address=0, WrData=A; → ALU_B. ALU_B: byte → WrEn, Address=1; → ALU_FUNC.
- ALU_FUNC: byte → ALU_FUN=byte[3:0], ALU_EN=1; → ALU_WAIT. ALU_WAIT: on OUT_Valid latch ALU_OUT → TX_BYTE with low byte, high byte held.
- TX_BYTE: when FIFO_FULL=0, TX_D_VLD=1, TX_P_DATA=held byte; → IDLE (read) or TX_HI (ALU). TX_HI: same with ALU_OUT[15:8]; → IDLE.
- CLKG_EN=1 in ALU_FUNC and ALU_WAIT, else 0.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_BYTE, TX_HI: byte discarded, DROP pulses.
- Response byte ordering: ALU low byte first, then high byte.

## Timing
- Reset: state IDLE; WrEn, RdEn, ALU_EN, TX_D_VLD, CLKG_EN, DROP = 0; Address, WrData, TX_P_DATA, ALU_FUN = 0.
- All outputs registered; strobes asserted the cycle after the RX_D_VLD that triggers them, exactly one cycle wide.
- Read: RX_D_VLD(addr) at n → RdEn at n+1 → RdData_Valid at n+2 → TX_D_VLD at n+3 if not full.
- ALU: RX_D_VLD(func) at n → ALU_EN at n+1 → OUT_Valid at n+2 → low byte n+3, high byte n+4 (FIFO not full).
- FIFO_FULL sampled each cycle in TX states; byte written the first cycle it is 0; data held stable while stalled.
- Address/WrData/ALU_FUN hold last value between strobes.
- Reset mid-frame: immediate return to IDLE, partial frame discarded, no strobe emitted.

## Structure
- Shared package: command opcodes (0xAA, 0xBB, 0xCC, 0xDD), state encoding, ALU operand register addresses (0, 1).
- Single flat module; no sub-module needed.

## Test plan
- Write: AA,05,3C → one WrEn with Address=5, WrData=0x3C; no TX_D_VLD.
- Read: preload reg 5=0x3C; BB,05 → RdEn Address=5; TX_P_DATA=0x3C one strobe, n+3 latency.
- ALU op: CC,08,07,00, ALU_OUT=0x000F → writes reg0=08, reg1=07, ALU_FUN=0, then TX bytes 0x0F, 0x00.
- ALU nop with backpressure: DD,02, ALU_OUT=0x0032, FIFO_FULL high 5 cycles → 0x32 sent after full drops, then 0x00; CLKG_EN high through ALU_WAIT.
- Robustness: byte 0x55 in IDLE ignored; byte during RD_WAIT → DROP pulse, frame completes normally.
- Reset after CC,0A → IDLE, no ALU_EN; following AA,02,81 writes correctly.
